// File: rtl/serial_paralelo_rx_pkg.sv
// Shared PHY lane definitions: comma byte, default lock threshold and the
// rx alignment state encoding (also used by the transmitter bench checker).
package serial_paralelo_rx_pkg;

  localparam logic [7:0] COMMA_BYTE      = 8'hBC;
  localparam int         SYNC_BC_DEFAULT = 4;

  // 2-bit encoding; value 3 is unused and recovers to SEARCH.
  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    SYNC   = 2'd1,
    ACTIVE = 2'd2
  } rx_state_e;

endpackage

// File: rtl/serial_paralelo_rx.sv
// Serial-to-parallel lane receiver. Hunts for the comma byte at any bit
// alignment, locks after SYNC_BC aligned commas, then presents each
// recovered non-comma byte with a valid flag and a byte-boundary strobe.
module serial_paralelo_rx
  import serial_paralelo_rx_pkg::*;
#(
  parameter logic [7:0] COMMA   = COMMA_BYTE,
  parameter int         SYNC_BC = SYNC_BC_DEFAULT
) (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic       data_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       byte_strobe,
  output logic       active
);

  // Lock threshold widened so bc_cnt+1 can be compared without overflow.
  localparam logic [4:0] SYNC_TGT = 5'(SYNC_BC);

  rx_state_e  state;
  logic [7:0] sr;
  logic [2:0] bit_cnt;
  logic [3:0] bc_cnt;

  logic [7:0] next_sr;
  logic       is_comma;
  logic       boundary;
  logic [4:0] bc_inc;

  // Decisions look at the shift register including the bit sampled this edge.
  always_comb begin
    next_sr  = {sr[6:0], data_in};
    is_comma = (next_sr == COMMA);
    boundary = (bit_cnt == 3'd7);
    bc_inc   = {1'b0, bc_cnt} + 5'd1;
  end

  // Alignment FSM with registered outputs.
  always_ff @(posedge clk_32f or posedge reset) begin
    if (reset) begin
      state       <= SEARCH;
      sr          <= '0;
      bit_cnt     <= '0;
      bc_cnt      <= '0;
      data_out    <= '0;
      valid_out   <= 1'b0;
      byte_strobe <= 1'b0;
      active      <= 1'b0;
    end else begin
      sr          <= next_sr;
      byte_strobe <= 1'b0;
      case (state)
        SEARCH: begin
          // Bit position is meaningless until a comma defines the alignment.
          if (is_comma) begin
            bit_cnt <= '0;
            bc_cnt  <= 4'd1;
            if (SYNC_TGT == 5'd1) begin
              state  <= ACTIVE;
              active <= 1'b1;
            end else begin
              state <= SYNC;
            end
          end
        end
        SYNC: begin
          bit_cnt <= bit_cnt + 3'd1;
          if (boundary) begin
            if (is_comma) begin
              if (bc_cnt != 4'hF) bc_cnt <= bc_inc[3:0];
              if (bc_inc == SYNC_TGT) begin
                state  <= ACTIVE;
                active <= 1'b1;
              end
            end else begin
              // Lost alignment: resume hunting at every bit offset.
              state  <= SEARCH;
              bc_cnt <= '0;
            end
          end
        end
        ACTIVE: begin
          bit_cnt <= bit_cnt + 3'd1;
          if (boundary) begin
            byte_strobe <= 1'b1;
            if (is_comma) begin
              valid_out <= 1'b0;
            end else begin
              data_out  <= next_sr;
              valid_out <= 1'b1;
            end
          end
        end
        default: begin
          state  <= SEARCH;
          bc_cnt <= '0;
          active <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_paralelo_rx.sv
// Directed bench for serial_paralelo_rx: reset, lock, loss of lock,
// arbitrary bit offset, idle insertion and asynchronous mid-byte reset.
module tb_serial_paralelo_rx;

  logic       clk_32f;
  logic       reset;
  logic       data_in;
  logic [7:0] data_out;
  logic       valid_out;
  logic       byte_strobe;
  logic       active;

  int tests;
  int fails;

  serial_paralelo_rx dut (
    .clk_32f    (clk_32f),
    .reset      (reset),
    .data_in    (data_in),
    .data_out   (data_out),
    .valid_out  (valid_out),
    .byte_strobe(byte_strobe),
    .active     (active)
  );

  initial clk_32f = 1'b0;
  always #5 clk_32f = ~clk_32f;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic [7:0] d, input logic v,
                          input logic s, input logic a);
    chk({tag, ".data"},   data_out,          d);
    chk({tag, ".valid"},  {7'd0, valid_out}, {7'd0, v});
    chk({tag, ".strobe"}, {7'd0, byte_strobe}, {7'd0, s});
    chk({tag, ".active"}, {7'd0, active},    {7'd0, a});
  endtask

  // One bit per rising edge; outputs are settled 1 time unit later.
  task automatic send_bit(input logic b);
    data_in = b;
    @(posedge clk_32f);
    #1;
  endtask

  // MSB first; optionally check that the strobe fires only on the last bit.
  task automatic send_byte(input logic [7:0] b, input bit chk_strb);
    for (int i = 7; i >= 0; i--) begin
      send_bit(b[i]);
      if (chk_strb) chk("strobe_pos", {7'd0, byte_strobe}, {7'd0, (i == 0)});
    end
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(posedge clk_32f);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    tests   = 0;
    fails   = 0;
    reset   = 1'b1;
    data_in = 1'b1;

    // 1: outputs stay cleared while reset is held
    for (int c = 0; c < 3; c++) begin
      @(posedge clk_32f);
      #1;
      chk_outs("t1_reset", 8'h00, 1'b0, 1'b0, 1'b0);
    end
    reset = 1'b0;

    // 2: aligned lock then two data bytes
    send_byte(8'hBC, 0);
    send_byte(8'hBC, 0);
    send_byte(8'hBC, 0);
    chk_outs("t2_3rd_bc", 8'h00, 1'b0, 1'b0, 1'b0);
    send_byte(8'hBC, 0);
    chk_outs("t2_lock", 8'h00, 1'b0, 1'b0, 1'b1);
    send_byte(8'hA5, 1);
    chk_outs("t2_a5", 8'hA5, 1'b1, 1'b1, 1'b1);
    send_byte(8'h3C, 1);
    chk_outs("t2_3c", 8'h3C, 1'b1, 1'b1, 1'b1);
    send_bit(1'b0);
    chk_outs("t2_hold", 8'h3C, 1'b1, 1'b0, 1'b1);

    // 3: broken comma run falls back to search, then relocks
    pulse_reset();
    send_byte(8'hBC, 0);
    send_byte(8'hBC, 0);
    send_byte(8'hBC, 0);
    send_byte(8'h55, 0);
    chk_outs("t3_break", 8'h00, 1'b0, 1'b0, 1'b0);
    send_byte(8'hBC, 0);
    send_byte(8'hBC, 0);
    send_byte(8'hBC, 0);
    chk_outs("t3_3rd_bc", 8'h00, 1'b0, 1'b0, 1'b0);
    send_byte(8'hBC, 0);
    chk("t3_lock", {7'd0, active}, 8'd1);
    send_byte(8'h77, 1);
    chk_outs("t3_77", 8'h77, 1'b1, 1'b1, 1'b1);

    // 4: alignment found after three junk bits
    pulse_reset();
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_byte(8'hBC, 0);
    send_byte(8'hBC, 0);
    send_byte(8'hBC, 0);
    chk("t4_3rd_bc", {7'd0, active}, 8'd0);
    send_byte(8'hBC, 0);
    chk("t4_lock", {7'd0, active}, 8'd1);
    send_byte(8'h81, 1);
    chk_outs("t4_81", 8'h81, 1'b1, 1'b1, 1'b1);

    // 5: idle byte between data bytes
    send_byte(8'h12, 1);
    chk_outs("t5_12", 8'h12, 1'b1, 1'b1, 1'b1);
    for (int i = 7; i >= 4; i--) send_bit(8'hBC >> i);
    chk_outs("t5_mid_bc", 8'h12, 1'b1, 1'b0, 1'b1);
    for (int i = 3; i >= 0; i--) send_bit(8'hBC >> i);
    chk_outs("t5_bc", 8'h12, 1'b0, 1'b1, 1'b1);
    send_byte(8'h34, 1);
    chk_outs("t5_34", 8'h34, 1'b1, 1'b1, 1'b1);

    // 6: asynchronous reset mid-byte while locked
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    chk("t6_pre", {7'd0, active}, 8'd1);
    #2;
    reset = 1'b1;
    #1;
    chk_outs("t6_async", 8'h00, 1'b0, 1'b0, 1'b0);
    @(posedge clk_32f);
    #1;
    reset = 1'b0;
    send_byte(8'hBC, 0);
    send_byte(8'hBC, 0);
    send_byte(8'hBC, 0);
    chk_outs("t6_3rd_bc", 8'h00, 1'b0, 1'b0, 1'b0);
    send_byte(8'hBC, 0);
    chk("t6_lock", {7'd0, active}, 8'd1);
    send_byte(8'h99, 1);
    chk_outs("t6_99", 8'h99, 1'b1, 1'b1, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
